// File: rtl/dut_check_seq_i8_pkg.sv
// Shared definitions for the CI vector sequencer: FSM encoding, the
// error-counter width and its saturating-increment helper.
package dut_check_seq_i8_pkg;

    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_APPLY = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] res;
        if (v == {ERR_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + ERR_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/dut_check_seq_i8_lat_counter.sv
// Loadable down-counter that paces the wait for a pipelined DUT result;
// terminal count is flagged while the count sits at one.
module lat_counter #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: load wins over decrement, never decrements past zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/dut_check_seq_i8.sv
// Self-checking vector sequencer: fetches (a, b, expected) triples, drives a
// two-operand 8-bit DUT, waits its latency and scores the result.
module dut_check_seq_i8
    import dut_check_seq_i8_pkg::*;
#(
    parameter int NVEC = 4,
    parameter int LAT  = 0,
    parameter int AW   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    vec_addr,
    input  logic [7:0]       vec_a,
    input  logic [7:0]       vec_b,
    input  logic [7:0]       vec_exp,
    output logic [7:0]       dut_a,
    output logic [7:0]       dut_b,
    input  logic [7:0]       dut_y,
    output logic             busy,
    output logic             fail,
    output logic             finish,
    output logic [ERR_W-1:0] err_count,
    output logic [AW-1:0]    first_err
);

    localparam int            CW       = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NVEC - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_idx;
    logic [7:0]       r_dut_a;
    logic [7:0]       r_dut_b;
    logic [7:0]       r_exp;
    logic             r_busy;
    logic             r_fail;
    logic             r_finish;
    logic [ERR_W-1:0] r_err_count;
    logic [AW-1:0]    r_first_err;
    logic             w_restart;
    logic             w_mismatch;
    logic             w_wait_done;
    logic             w_next_busy;

    // A finished run accepts a new start only once finish has been shown.
    assign w_restart   = start && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_DONE) && r_finish));
    assign w_mismatch  = (dut_y != r_exp);
    assign w_next_busy = (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);

    generate
        if (LAT > 0) begin : g_lat
            lat_counter #(.W(CW)) u_lat (
                .i_clk      (clock),
                .i_rst_n    (reset),
                .i_load     (r_state == ST_APPLY),
                .i_load_val (CW'(LAT)),
                .i_dec      (r_state == ST_WAIT),
                .o_tc       (w_wait_done)
            );
        end else begin : g_no_lat
            assign w_wait_done = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_restart) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_FETCH: w_next_state = ST_APPLY;
            ST_APPLY: begin
                if (LAT > 0) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (w_wait_done) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_CHECK: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath, scoreboard and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx       <= {AW{1'b0}};
            r_dut_a     <= 8'd0;
            r_dut_b     <= 8'd0;
            r_exp       <= 8'd0;
            r_busy      <= 1'b0;
            r_fail      <= 1'b0;
            r_finish    <= 1'b0;
            r_err_count <= {ERR_W{1'b0}};
            r_first_err <= {AW{1'b0}};
        end else begin
            r_busy <= w_next_busy;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_restart) begin
                        r_idx       <= {AW{1'b0}};
                        r_fail      <= 1'b0;
                        r_finish    <= 1'b0;
                        r_err_count <= {ERR_W{1'b0}};
                        r_first_err <= {AW{1'b0}};
                    end else begin
                        r_finish <= (r_state == ST_DONE);
                    end
                end
                ST_APPLY: begin
                    r_dut_a <= vec_a;
                    r_dut_b <= vec_b;
                    r_exp   <= vec_exp;
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        r_fail      <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                        if (!r_fail) begin
                            r_first_err <= r_idx;
                        end
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign vec_addr  = r_idx;
    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign busy      = r_busy;
    assign fail      = r_fail;
    assign finish    = r_finish;
    assign err_count = r_err_count;
    assign first_err = r_first_err;

endmodule
